// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin sharing of one memory request port between the
// non-cache (N), I$ (I) and D$ (D) requesters, one transaction in flight at a time.
module mem_req_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               n_req_valid,
    input  logic [WIDTH-1:0]   n_req_addr,
    input  logic [WIDTH-1:0]   n_req_data,
    input  logic [WIDTH/8-1:0] n_req_mask,
    output logic               n_resp_valid,
    output logic [WIDTH-1:0]   n_resp_data,
    input  logic               i_req_valid,
    input  logic [WIDTH-1:0]   i_req_addr,
    input  logic [WIDTH-1:0]   i_req_data,
    input  logic [WIDTH/8-1:0] i_req_mask,
    output logic               i_resp_valid,
    output logic [WIDTH-1:0]   i_resp_data,
    input  logic               d_req_valid,
    input  logic [WIDTH-1:0]   d_req_addr,
    input  logic [WIDTH-1:0]   d_req_data,
    input  logic [WIDTH/8-1:0] d_req_mask,
    output logic               d_resp_valid,
    output logic [WIDTH-1:0]   d_resp_data,
    output logic               m_req_valid,
    output logic [WIDTH-1:0]   m_req_addr,
    output logic [WIDTH-1:0]   m_req_data,
    output logic [WIDTH/8-1:0] m_req_mask,
    input  logic               m_resp_valid,
    input  logic [WIDTH-1:0]   m_resp_data,
    output logic [1:0]         grant_id,
    output logic               busy,
    output logic               timeout_err
);
    localparam int MW = WIDTH / 8;
    localparam logic [WIDTH-1:0] ERR_DATA  = WIDTH'(32'hDEADBEEF);
    localparam logic [WIDTH-1:0] WDOG_LAST = WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state, w_state;
    logic [1:0]       r_last_grant, w_last_grant;
    logic [1:0]       r_grant_id, w_grant_id;
    logic             r_m_req_valid, w_m_req_valid;
    logic [WIDTH-1:0] r_m_req_addr, w_m_req_addr;
    logic [WIDTH-1:0] r_m_req_data, w_m_req_data;
    logic [MW-1:0]    r_m_req_mask, w_m_req_mask;
    logic [WIDTH-1:0] r_wdog, w_wdog;
    logic [2:0]       r_resp_valid, w_resp_valid;
    logic [WIDTH-1:0] r_resp_data [3];
    logic [WIDTH-1:0] w_resp_data [3];
    logic             r_busy, w_busy;
    logic             r_timeout_err, w_timeout_err;

    logic [2:0]       w_req_valid;
    logic [WIDTH-1:0] w_req_addr [3];
    logic [WIDTH-1:0] w_req_data [3];
    logic [MW-1:0]    w_req_mask [3];
    logic [1:0]       w_win;
    logic             w_expire;

    // Search starts one past the previous owner so every requester gets a turn.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        rr_pick = 2'd0;
        found   = 1'b0;
        idx     = last;
        for (int k = 0; k < 3; k++) begin
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign w_req_valid   = {d_req_valid, i_req_valid, n_req_valid};
    assign w_req_addr[0] = n_req_addr;
    assign w_req_addr[1] = i_req_addr;
    assign w_req_addr[2] = d_req_addr;
    assign w_req_data[0] = n_req_data;
    assign w_req_data[1] = i_req_data;
    assign w_req_data[2] = d_req_data;
    assign w_req_mask[0] = n_req_mask;
    assign w_req_mask[1] = i_req_mask;
    assign w_req_mask[2] = d_req_mask;

    assign w_win    = rr_pick(w_req_valid, r_last_grant);
    assign w_expire = (TIMEOUT != 0) && (r_wdog == WDOG_LAST);

    always_comb begin
        w_state       = r_state;
        w_last_grant  = r_last_grant;
        w_grant_id    = r_grant_id;
        w_m_req_valid = r_m_req_valid;
        w_m_req_addr  = r_m_req_addr;
        w_m_req_data  = r_m_req_data;
        w_m_req_mask  = r_m_req_mask;
        w_wdog        = r_wdog;
        w_resp_valid  = 3'b000;
        w_resp_data   = r_resp_data;
        w_timeout_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_req_valid) begin
                    w_state       = S_BUSY;
                    w_grant_id    = w_win;
                    w_last_grant  = w_win;
                    w_m_req_valid = 1'b1;
                    w_m_req_addr  = w_req_addr[w_win];
                    w_m_req_data  = w_req_data[w_win];
                    w_m_req_mask  = w_req_mask[w_win];
                    w_wdog        = '0;
                end
            end
            S_BUSY: begin
                // A real response always beats a watchdog expiry in the same cycle.
                if (m_resp_valid || w_expire) begin
                    w_state       = S_RESP;
                    w_m_req_valid = 1'b0;
                    w_timeout_err = !m_resp_valid;
                    for (int k = 0; k < 3; k++) begin
                        if (r_grant_id == 2'(k)) begin
                            w_resp_valid[k] = 1'b1;
                            w_resp_data[k]  = m_resp_valid ? m_resp_data : ERR_DATA;
                        end
                    end
                end else if (r_wdog != '1) begin
                    w_wdog = r_wdog + WIDTH'(1);
                end
            end
            S_RESP:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_last_grant  <= 2'd2;
            r_grant_id    <= 2'd0;
            r_m_req_valid <= 1'b0;
            r_m_req_addr  <= '0;
            r_m_req_data  <= '0;
            r_m_req_mask  <= '0;
            r_wdog        <= '0;
            r_resp_valid  <= 3'b000;
            for (int k = 0; k < 3; k++) r_resp_data[k] <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_last_grant  <= w_last_grant;
            r_grant_id    <= w_grant_id;
            r_m_req_valid <= w_m_req_valid;
            r_m_req_addr  <= w_m_req_addr;
            r_m_req_data  <= w_m_req_data;
            r_m_req_mask  <= w_m_req_mask;
            r_wdog        <= w_wdog;
            r_resp_valid  <= w_resp_valid;
            for (int k = 0; k < 3; k++) r_resp_data[k] <= w_resp_data[k];
            r_busy        <= w_busy;
            r_timeout_err <= w_timeout_err;
        end
    end

    assign n_resp_valid = r_resp_valid[0];
    assign i_resp_valid = r_resp_valid[1];
    assign d_resp_valid = r_resp_valid[2];
    assign n_resp_data  = r_resp_data[0];
    assign i_resp_data  = r_resp_data[1];
    assign d_resp_data  = r_resp_data[2];
    assign m_req_valid  = r_m_req_valid;
    assign m_req_addr   = r_m_req_addr;
    assign m_req_data   = r_m_req_data;
    assign m_req_mask   = r_m_req_mask;
    assign grant_id     = r_grant_id;
    assign busy         = r_busy;
    assign timeout_err  = r_timeout_err;
endmodule
